// File: rtl/coin_acceptor.sv
// coin_acceptor
//   Front end for the vending FSM. Four raw coin-slot sensor lines are
//   synchronised and debounced. Each clean insertion becomes a 2-bit coin
//   code. The code is queued in a small FIFO and offered over valid/ready.
//   Ambiguous insertions, insertions into a full queue, and insertions after
//   a jam are kept out of the queue.
//
// Parameters
//   DEBOUNCE    cycles a synced line must differ before the stable level follows
//   JAM_CYCLES  consecutive stable-high cycles on one line that declare a jam
//   FIFO_DEPTH  coin event queue depth (power of two, >= 2)
//
// Ports
//   clk          system clock, rising edge
//   rst_n        synchronous active-low reset
//   coin_in      raw sensor lines: bit0 Rs.5, bit1 Rs.10, bit2 Rs.15, bit3 Rs.20
//   coin_ready   consumer takes the head entry this cycle
//   coin_valid   queue non-empty, coin_code valid (registered)
//   coin_code    head entry: 00 Rs.5, 01 Rs.10, 10 Rs.15, 11 Rs.20 (registered)
//   coin_reject  one-cycle pulse, coin goes to the return chute (registered)
//   fifo_full    queue holds FIFO_DEPTH entries (registered)
//   jam          sticky jam flag, cleared only by reset
module coin_acceptor #(
  parameter int DEBOUNCE   = 4,
  parameter int JAM_CYCLES = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] coin_in,
  input  logic       coin_ready,
  output logic       coin_valid,
  output logic [1:0] coin_code,
  output logic       coin_reject,
  output logic       fifo_full,
  output logic       jam
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int DB_W  = $clog2(DEBOUNCE + 1);
  localparam int JC_W  = $clog2(JAM_CYCLES + 1);

  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE - 1);
  localparam logic [JC_W-1:0]  JC_LIMIT = JC_W'(JAM_CYCLES);
  localparam logic [CNT_W-1:0] OCC_FULL = CNT_W'(FIFO_DEPTH);

  // Synchroniser and debouncer state
  logic [3:0]      sync1_q, sync2_q;
  logic [3:0]      stable_q, stable_d;
  logic [3:0]      stable_prev_q;
  logic [DB_W-1:0] db_cnt_q [4];
  logic [DB_W-1:0] db_cnt_d [4];

  // Jam monitor state
  logic [JC_W-1:0] jam_cnt_q [4];
  logic [JC_W-1:0] jam_cnt_d [4];
  logic            jam_q, jam_d;

  // FIFO state
  logic [1:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Registered outputs
  logic       coin_valid_q;
  logic [1:0] coin_code_q, coin_code_d;
  logic       coin_reject_q, coin_reject_d;
  logic       fifo_full_q;

  // Classification signals
  logic [3:0] rise;
  logic       single_rise;
  logic       other_high;
  logic       legal;
  logic       ambiguous;
  logic       full;
  logic       pop;
  logic       push;
  logic       drop;
  logic [1:0] push_code;

  // Debounce and jam counters, one lane per sensor line
  always_comb begin
    jam_d = jam_q;
    for (int i = 0; i < 4; i++) begin
      stable_d[i]  = stable_q[i];
      db_cnt_d[i]  = '0;
      jam_cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          stable_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
        end
      end
      // Saturate so a line held forever cannot wrap and lose the jam.
      if (stable_q[i]) begin
        if (jam_cnt_q[i] < JC_LIMIT) begin
          jam_cnt_d[i] = jam_cnt_q[i] + JC_W'(1);
        end else begin
          jam_cnt_d[i] = jam_cnt_q[i];
        end
      end
      if (jam_cnt_q[i] == JC_LIMIT) begin
        jam_d = 1'b1;
      end
    end
  end

  // Event classification and FIFO next state
  always_comb begin
    rise        = stable_q & ~stable_prev_q;
    single_rise = (rise != 4'd0) && ((rise & (rise - 4'd1)) == 4'd0);
    // A line already held high (not rising now) makes any new edge ambiguous.
    other_high  = |(stable_q & ~rise);
    legal       = !jam_q && single_rise && !other_high;
    ambiguous   = !jam_q && (rise != 4'd0) && !legal;

    full = (count_q == OCC_FULL);
    pop  = coin_valid_q && coin_ready;
    push = legal && (!full || pop);
    drop = legal && full && !pop;
    coin_reject_d = ambiguous || drop;

    push_code = 2'd0;
    case (rise)
      4'b0010: push_code = 2'd1;
      4'b0100: push_code = 2'd2;
      4'b1000: push_code = 2'd3;
      default: push_code = 2'd0;
    endcase

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end

    // The new head may be the entry being written this very cycle.
    if (count_d == '0) begin
      coin_code_d = 2'd0;
    end else if (push && (wr_ptr_q == rd_ptr_d)) begin
      coin_code_d = push_code;
    end else begin
      coin_code_d = mem_q[rd_ptr_d];
    end
  end

  // Registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      stable_q      <= '0;
      stable_prev_q <= '0;
      for (int i = 0; i < 4; i++) begin
        db_cnt_q[i]  <= '0;
        jam_cnt_q[i] <= '0;
      end
      jam_q         <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      coin_valid_q  <= 1'b0;
      coin_code_q   <= 2'd0;
      coin_reject_q <= 1'b0;
      fifo_full_q   <= 1'b0;
    end else begin
      sync1_q       <= coin_in;
      sync2_q       <= sync1_q;
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      for (int i = 0; i < 4; i++) begin
        db_cnt_q[i]  <= db_cnt_d[i];
        jam_cnt_q[i] <= jam_cnt_d[i];
      end
      jam_q         <= jam_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      coin_valid_q  <= (count_d != '0);
      coin_code_q   <= coin_code_d;
      coin_reject_q <= coin_reject_d;
      fifo_full_q   <= (count_d == OCC_FULL);
    end
  end

  // Queue storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem_q[wr_ptr_q] <= push_code;
    end
  end

  assign coin_valid  = coin_valid_q;
  assign coin_code   = coin_code_q;
  assign coin_reject = coin_reject_q;
  assign fifo_full   = fifo_full_q;
  assign jam         = jam_q;

endmodule

// File: tb/tb_coin_acceptor.sv
module tb_coin_acceptor;

  localparam int DEB   = 4;
  localparam int JAMC  = 64;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] coin_in = 4'd0;
  logic       coin_ready = 1'b0;
  logic       coin_valid;
  logic [1:0] coin_code;
  logic       coin_reject;
  logic       fifo_full;
  logic       jam;

  coin_acceptor #(.DEBOUNCE(DEB), .JAM_CYCLES(JAMC), .FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .coin_in     (coin_in),
    .coin_ready  (coin_ready),
    .coin_valid  (coin_valid),
    .coin_code   (coin_code),
    .coin_reject (coin_reject),
    .fifo_full   (fifo_full),
    .jam         (jam)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference model: each line's synced level is the raw level two edges
  // late; the stable level follows it once it has disagreed for DEB
  // consecutive cycles. Coin events live in a queue.
  int m_s1 [4];
  int m_s2 [4];
  int m_stb [4];
  int m_prv [4];
  int m_run [4];
  int m_hi [4];
  int m_q [$];
  int m_jam, m_valid, m_code, m_rej, m_full;
  int n_rise, n_other, m_idx;
  bit m_pop, m_legal, m_push, m_jam_n;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        m_s1[i] = 0; m_s2[i] = 0; m_stb[i] = 0; m_prv[i] = 0; m_run[i] = 0; m_hi[i] = 0;
      end
      m_q.delete();
      m_jam = 0; m_valid = 0; m_code = 0; m_rej = 0; m_full = 0;
    end else begin
      n_rise = 0; n_other = 0; m_idx = 0;
      for (int i = 0; i < 4; i++) begin
        if (m_stb[i] != 0 && m_prv[i] == 0) begin
          n_rise++;
          m_idx = i;
        end else if (m_stb[i] != 0) begin
          n_other++;
        end
      end
      m_pop   = (m_valid != 0) && coin_ready;
      m_legal = (m_jam == 0) && (n_rise == 1) && (n_other == 0);
      m_rej   = ((m_jam == 0) && (n_rise > 0) && !m_legal) ? 1 : 0;
      if (m_legal && m_q.size() == DEPTH && !m_pop) m_rej = 1;
      m_push  = m_legal && (m_q.size() < DEPTH || m_pop);
      if (m_pop) void'(m_q.pop_front());
      if (m_push) m_q.push_back(m_idx);
      m_jam_n = (m_jam != 0);
      for (int i = 0; i < 4; i++) if (m_hi[i] >= JAMC) m_jam_n = 1'b1;
      m_jam = m_jam_n ? 1 : 0;
      for (int i = 0; i < 4; i++) begin
        m_hi[i]  = (m_stb[i] != 0) ? ((m_hi[i] < JAMC) ? m_hi[i] + 1 : JAMC) : 0;
        m_prv[i] = m_stb[i];
        if (m_s2[i] != m_stb[i]) begin
          m_run[i]++;
          if (m_run[i] == DEB) begin
            m_stb[i] = m_s2[i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
        m_s2[i] = m_s1[i];
        m_s1[i] = int'(coin_in[i]);
      end
      m_valid = (m_q.size() > 0) ? 1 : 0;
      m_code  = (m_q.size() > 0) ? m_q[0] : 0;
      m_full  = (m_q.size() == DEPTH) ? 1 : 0;
    end
  end

  int cyc = 0;
  int vcnt = 0;
  int rcnt = 0;
  int first_v = -1;
  int fv_code = -1;
  int jam_at = -1;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    check("valid", coin_valid, m_valid);
    check("code", coin_code, m_code);
    check("reject", coin_reject, m_rej);
    check("full", fifo_full, m_full);
    check("jam", jam, m_jam);
    if (coin_valid) vcnt++;
    if (coin_reject) rcnt++;
    if (coin_valid && first_v < 0) begin
      first_v = cyc;
      fv_code = int'(coin_code);
    end
    if (jam && jam_at < 0) jam_at = cyc;
  endtask

  task automatic hold(input logic [3:0] v, input int n);
    coin_in = v;
    for (int k = 0; k < n; k++) tick();
  endtask

  int t0, v0, r0;
  int pat, hl, gp;

  initial begin
    // Reset held with a sensor line active
    rst_n = 1'b0;
    coin_in = 4'b0010;
    tick();
    check("rst_outs_1", {coin_valid, coin_code, coin_reject, fifo_full, jam}, 0);
    tick();
    check("rst_outs_2", {coin_valid, coin_code, coin_reject, fifo_full, jam}, 0);
    coin_in = 4'd0;
    rst_n = 1'b1;
    vcnt = 0; rcnt = 0;
    hold(4'd0, 10);
    check("rst_no_event", vcnt + rcnt, 0);

    // Single Rs.15 coin
    coin_ready = 1'b1;
    vcnt = 0; rcnt = 0; first_v = -1;
    t0 = cyc + 1;
    hold(4'b0100, 10);
    hold(4'd0, 10);
    check("single_vcycles", vcnt, 1);
    check("single_latency", first_v - t0, 6);
    check("single_code", fv_code, 2);
    check("single_noreject", rcnt, 0);

    // Bouncing Rs.5
    vcnt = 0; rcnt = 0; first_v = -1;
    hold(4'b0001, 1);
    hold(4'b0000, 1);
    hold(4'b0001, 1);
    hold(4'b0000, 1);
    hold(4'b0001, 8);
    hold(4'd0, 10);
    check("bounce_events", vcnt, 1);
    check("bounce_code", fv_code, 0);
    check("bounce_noreject", rcnt, 0);

    // Queueing and overflow
    coin_ready = 1'b0;
    rcnt = 0;
    for (int k = 0; k < 4; k++) begin
      hold(4'b0001 << k, 5);
      hold(4'd0, 5);
    end
    check("queue_full", fifo_full, 1);
    check("queue_noreject", rcnt, 0);
    hold(4'b0001, 5);
    hold(4'd0, 5);
    check("overflow_reject", rcnt, 1);
    check("overflow_still_full", fifo_full, 1);
    coin_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("drain_valid", coin_valid, 1);
      check("drain_code", coin_code, k);
      tick();
    end
    check("drain_empty", coin_valid, 0);
    check("drain_notfull", fifo_full, 0);

    // Two lines at once
    vcnt = 0; rcnt = 0;
    hold(4'b1001, 10);
    hold(4'd0, 10);
    check("simul_reject", rcnt, 1);
    check("simul_nopush", vcnt, 0);

    // Jam on Rs.10
    vcnt = 0; rcnt = 0; jam_at = -1;
    t0 = cyc + 1;
    hold(4'b0010, 80);
    check("jam_one_event", vcnt, 1);
    check("jam_edge", jam_at - t0, 70);
    hold(4'd0, 10);
    v0 = vcnt; r0 = rcnt;
    hold(4'b1000, 10);
    hold(4'd0, 10);
    check("jam_ignore_push", vcnt - v0, 0);
    check("jam_ignore_reject", rcnt - r0, 0);
    check("jam_sticky", jam, 1);

    // Reset mid-debounce with the queue idle; jam must clear
    coin_ready = 1'b0;
    hold(4'b0001, 3);
    rst_n = 1'b0;
    hold(4'b0001, 2);
    check("jam_cleared", jam, 0);
    rst_n = 1'b1;
    vcnt = 0; rcnt = 0;
    hold(4'd0, 12);
    check("post_rst_quiet", vcnt + rcnt, 0);

    // Randomized insertions with random back-pressure
    for (int n = 0; n < 40; n++) begin
      pat = ($urandom_range(0, 9) < 7) ? (1 << $urandom_range(0, 3)) : $urandom_range(1, 15);
      hl = $urandom_range(1, 14);
      gp = $urandom_range(2, 12);
      coin_in = 4'(pat);
      for (int k = 0; k < hl; k++) begin
        coin_ready = 1'($urandom_range(0, 1));
        tick();
      end
      coin_in = 4'd0;
      for (int k = 0; k < gp; k++) begin
        coin_ready = 1'($urandom_range(0, 1));
        tick();
      end
    end
    coin_ready = 1'b1;
    hold(4'd0, 12);
    check("final_drained", coin_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
